// File: rtl/sdc_xfer_sequencer_pkg.sv
// Shared types and constants for the SD transfer sequencer: FSM states, completion
// status codes, command indices and datapath interruptEvents bit positions.
package sdc_pkg;

  localparam int unsigned STATUS_W   = 3;
  localparam int unsigned CMD_IDX_W  = 6;
  localparam int unsigned EVENTS_W   = 7;
  localparam int unsigned ERR_BITS_W = 5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RX_ARM,
    ST_ARM_WAIT,
    ST_CMD,
    ST_CMD_WAIT,
    ST_TX_ARM,
    ST_TX_WAIT,
    ST_DATA_WAIT,
    ST_STOP,
    ST_STOP_WAIT,
    ST_BUSY_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic [STATUS_W-1:0] {
    STS_OK       = 3'd0,
    STS_CMD_ERR  = 3'd1,
    STS_DATA_ERR = 3'd2,
    STS_STOP_ERR = 3'd3,
    STS_WDOG     = 3'd4
  } status_t;

  localparam logic [CMD_IDX_W-1:0] CMD12 = 6'd12;
  localparam logic [CMD_IDX_W-1:0] CMD17 = 6'd17;
  localparam logic [CMD_IDX_W-1:0] CMD18 = 6'd18;
  localparam logic [CMD_IDX_W-1:0] CMD24 = 6'd24;
  localparam logic [CMD_IDX_W-1:0] CMD25 = 6'd25;

  localparam int unsigned EV_CLEAN  = 0;
  localparam int unsigned EV_ERR    = 1;
  localparam int unsigned EV_DET_LO = 2;
  localparam int unsigned EV_DET_HI = 6;

  // Standard-capacity cards are byte addressed, high-capacity cards block addressed.
  function automatic logic [31:0] card_arg(input logic [31:0] lba, input logic high_capacity);
    return high_capacity ? lba : {lba[22:0], 9'b0};
  endfunction

  function automatic logic [CMD_IDX_W-1:0] xfer_cmd(input logic write, input logic single);
    if (single) return write ? CMD24 : CMD17;
    return write ? CMD25 : CMD18;
  endfunction

endpackage

// File: rtl/sdc_xfer_sequencer_if.sv
// Request, command-engine, datapath and completion signals of the transfer sequencer.
interface sdc_xfer_sequencer_if #(
  parameter int unsigned BLKCNT_W = 16
);
  import sdc_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [31:0]           req_lba;
  logic [BLKCNT_W-1:0]   req_count;
  logic [31:0]           req_dma;
  logic                  high_capacity;

  logic                  cmd_start;
  logic [CMD_IDX_W-1:0]  cmd_index;
  logic [31:0]           cmd_arg;
  logic                  cmd_done;
  logic                  cmd_error;

  logic [BLKCNT_W-1:0]   dp_block_count;
  logic [31:0]           dp_dma_addr;
  logic                  dp_rx_start;
  logic                  dp_tx_start;
  logic [EVENTS_W-1:0]   dp_events;
  logic                  dp_busy;

  logic                  done;
  logic [STATUS_W-1:0]   done_status;
  logic [ERR_BITS_W-1:0] done_err_bits;

  modport slave (
    input  req_valid, req_write, req_lba, req_count, req_dma, high_capacity,
    input  cmd_done, cmd_error, dp_events, dp_busy,
    output req_ready, cmd_start, cmd_index, cmd_arg,
    output dp_block_count, dp_dma_addr, dp_rx_start, dp_tx_start,
    output done, done_status, done_err_bits
  );

  modport master (
    output req_valid, req_write, req_lba, req_count, req_dma, high_capacity,
    output cmd_done, cmd_error, dp_events, dp_busy,
    input  req_ready, cmd_start, cmd_index, cmd_arg,
    input  dp_block_count, dp_dma_addr, dp_rx_start, dp_tx_start,
    input  done, done_status, done_err_bits
  );

endinterface

// File: rtl/sdc_xfer_sequencer.sv
// Sequences one SD block transfer: arms the datapath, issues the read/write command,
// waits for data, issues CMD12 after multi-block transfers and reports one status.
module sdc_xfer_sequencer #(
  parameter int unsigned BLKCNT_W = 16,
  parameter int unsigned WDOG_W   = 28
) (
  input logic                 clk,
  input logic                 rst,
  sdc_xfer_sequencer_if.slave bus
);
  import sdc_pkg::*;

  state_t              state;
  state_t              state_next;
  status_t             status_q;
  status_t             status_next;
  logic                write_q;
  logic                multi_q;
  logic [WDOG_W-1:0]   wdog_q;
  logic                accept_c;
  logic                active_c;
  logic                wdog_exp_c;
  logic                data_end_c;
  logic                cmd_resp_c;

  // State and accumulated status register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      status_q <= STS_OK;
    end else begin
      state    <= state_next;
      status_q <= status_next;
    end
  end

  // Next state and status; the watchdog overrides every other transition.
  always_comb begin
    state_next  = state;
    status_next = status_q;
    accept_c    = (state == ST_IDLE) && bus.req_valid;
    active_c    = (state != ST_IDLE) && (state != ST_DONE);
    wdog_exp_c  = active_c && (wdog_q == {WDOG_W{1'b1}});
    data_end_c  = bus.dp_events[EV_CLEAN] | bus.dp_events[EV_ERR] |
                  (|bus.dp_events[EV_DET_HI:EV_DET_LO]);
    cmd_resp_c  = bus.cmd_done | bus.cmd_error;

    unique case (state)
      ST_IDLE: begin
        if (accept_c) begin
          status_next = STS_OK;
          if (bus.req_count == '0)  state_next = ST_DONE;
          else if (bus.req_write)   state_next = ST_CMD;
          else                      state_next = ST_RX_ARM;
        end
      end
      ST_RX_ARM:   state_next = ST_ARM_WAIT;
      ST_ARM_WAIT: if (bus.dp_events == '0) state_next = ST_CMD;
      ST_CMD:      state_next = ST_CMD_WAIT;
      ST_CMD_WAIT: begin
        // An error wins when done and error arrive together.
        if (bus.cmd_error) begin
          status_next = STS_CMD_ERR;
          state_next  = write_q ? ST_DONE : ST_DATA_WAIT;
        end else if (bus.cmd_done) begin
          state_next  = write_q ? ST_TX_ARM : ST_DATA_WAIT;
        end
      end
      ST_TX_ARM:   state_next = ST_TX_WAIT;
      ST_TX_WAIT:  if (bus.dp_events == '0) state_next = ST_DATA_WAIT;
      ST_DATA_WAIT: begin
        if (data_end_c) begin
          if (bus.dp_events[EV_ERR] && (status_q == STS_OK)) status_next = STS_DATA_ERR;
          if (multi_q)      state_next = ST_STOP;
          else if (write_q) state_next = ST_BUSY_WAIT;
          else              state_next = ST_DONE;
        end
      end
      ST_STOP:     state_next = ST_STOP_WAIT;
      ST_STOP_WAIT: begin
        if (cmd_resp_c) begin
          if (bus.cmd_error && (status_q == STS_OK)) status_next = STS_STOP_ERR;
          state_next = write_q ? ST_BUSY_WAIT : ST_DONE;
        end
      end
      ST_BUSY_WAIT: if (!bus.dp_busy) state_next = ST_DONE;
      ST_DONE:      state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase

    if (wdog_exp_c) begin
      state_next  = ST_DONE;
      status_next = STS_WDOG;
    end
  end

  // Registered outputs, request latches and watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.req_ready      <= 1'b1;
      bus.cmd_start      <= 1'b0;
      bus.cmd_index      <= '0;
      bus.cmd_arg        <= '0;
      bus.dp_block_count <= '0;
      bus.dp_dma_addr    <= '0;
      bus.dp_rx_start    <= 1'b0;
      bus.dp_tx_start    <= 1'b0;
      bus.done           <= 1'b0;
      bus.done_status    <= '0;
      bus.done_err_bits  <= '0;
      write_q            <= 1'b0;
      multi_q            <= 1'b0;
      wdog_q             <= '0;
    end else begin
      bus.req_ready   <= (state_next == ST_IDLE);
      bus.cmd_start   <= (state_next == ST_CMD) || (state_next == ST_STOP);
      bus.dp_rx_start <= (state_next == ST_RX_ARM);
      bus.dp_tx_start <= (state_next == ST_TX_ARM);
      bus.done        <= (state_next == ST_DONE);

      if (accept_c)      wdog_q <= '0;
      else if (active_c) wdog_q <= wdog_q + WDOG_W'(1);

      if (accept_c) begin
        write_q            <= bus.req_write;
        multi_q            <= bus.req_count > BLKCNT_W'(1);
        bus.dp_block_count <= bus.req_count;
        bus.dp_dma_addr    <= bus.req_dma;
        bus.cmd_index      <= xfer_cmd(bus.req_write, bus.req_count == BLKCNT_W'(1));
        bus.cmd_arg        <= card_arg(bus.req_lba, bus.high_capacity);
        bus.done_err_bits  <= '0;
      end

      if (state_next == ST_STOP) begin
        bus.cmd_index <= CMD12;
        bus.cmd_arg   <= '0;
      end

      if ((state == ST_DATA_WAIT) && data_end_c)
        bus.done_err_bits <= bus.dp_events[EV_DET_HI:EV_DET_LO];

      if (state_next == ST_DONE)
        bus.done_status <= STATUS_W'(status_next);
    end
  end

endmodule

// File: tb/tb_sdc_xfer_sequencer.sv
// Randomized bench for sdc_xfer_sequencer: a reactive card/datapath responder plus a
// reference model of the expected command sequence, status and timing per request.
module tb_sdc_xfer_sequencer;
  localparam int unsigned BLKCNT_W = 16;
  localparam int unsigned WDOG_W   = 8;
  localparam int          MAX_CYC  = 600;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  sdc_xfer_sequencer_if #(.BLKCNT_W(BLKCNT_W)) bus ();

  sdc_xfer_sequencer #(.BLKCNT_W(BLKCNT_W), .WDOG_W(WDOG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.req_valid     = 1'b0;
    bus.req_write     = 1'b0;
    bus.req_lba       = '0;
    bus.req_count     = '0;
    bus.req_dma       = '0;
    bus.high_capacity = 1'b0;
    bus.cmd_done      = 1'b0;
    bus.cmd_error     = 1'b0;
    bus.dp_events     = '0;
    bus.dp_busy       = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, "_pulses"}, 32'({bus.cmd_start, bus.dp_rx_start, bus.dp_tx_start, bus.done}), 32'd0);
    check({tag, "_cmd"}, 32'({bus.cmd_index, bus.done_status, bus.done_err_bits}), 32'd0);
    check({tag, "_arg"}, bus.cmd_arg, 32'd0);
    check({tag, "_dp"}, 32'(bus.dp_block_count) | bus.dp_dma_addr, 32'd0);
  endtask

  // mode 0: normal, 1: data never completes (watchdog), 2: async reset in the data phase
  task automatic run_xfer(input logic w, input logic [31:0] lba, input logic [15:0] cnt,
                          input logic hc, input logic cerr, input logic [6:0] ev,
                          input logic serr, input logic junk, input int busy_len, input int mode);
    int cyc = 0, done_cyc = 0, busy_fall = 0, cresp_cyc = 0;
    int ncmd = 0, ntx = 0, nrx = 0, nstop = 0;
    int cmd_wait = 0, ev_clr = 0, data_wait = 0, busy_cnt = 0;
    logic rx_before = 0, cur_stop = 0, last_tx = 0, got_done = 0, ready_viol = 0, err;
    logic [5:0]  idx0 = '0;
    logic [31:0] arg0 = '0, stop_arg = '0, dma;
    logic [2:0]  st = '0;
    logic [4:0]  eb = '0;
    logic        multi = (cnt > 16'd1);
    logic [5:0]  exp_idx = (cnt == 16'd1) ? (w ? 6'd24 : 6'd17) : (w ? 6'd25 : 6'd18);
    logic [31:0] exp_arg = hc ? lba : lba * 32'd512;
    logic [2:0]  exp_st;
    logic [4:0]  exp_eb;

    dma = $urandom;
    @(negedge clk);
    check("ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_lba = lba;
    bus.req_count = cnt;  bus.req_dma = dma; bus.high_capacity = hc;

    while (!got_done && cyc < MAX_CYC) begin
      @(negedge clk);
      cyc++;
      bus.cmd_done  = 1'b0;
      bus.cmd_error = 1'b0;

      if (mode == 2 && cresp_cyc > 0 && cyc == cresp_cyc + 3) begin
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_mid");
        drive_idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
          @(negedge clk);
          if (bus.done || !bus.req_ready) ready_viol = 1'b1;
        end
        check("rst_no_done", 32'(ready_viol), 32'd0);
        return;
      end

      if (bus.done) begin
        got_done = 1'b1; done_cyc = cyc; st = bus.done_status; eb = bus.done_err_bits;
      end
      if (bus.req_ready) ready_viol = 1'b1;
      if (junk && !got_done) begin
        bus.req_valid = 1'($urandom_range(0, 1));
        bus.req_write = 1'($urandom_range(0, 1));
        bus.req_lba   = $urandom;
        bus.req_count = 16'($urandom);
        bus.req_dma   = $urandom;
      end else begin
        bus.req_valid = 1'b0;
      end

      // Responder: command responses, datapath start/finish and card busy.
      if (cmd_wait > 0) begin
        cmd_wait--;
        if (cmd_wait == 0) begin
          err = cur_stop ? serr : cerr;
          bus.cmd_error = err;
          bus.cmd_done  = err ? 1'($urandom_range(0, 1)) : 1'b1;
          if (!cur_stop) begin
            cresp_cyc = cyc;
            if (!w && mode == 0) data_wait = $urandom_range(2, 8);
          end
        end
      end
      if (ev_clr > 0) begin
        ev_clr--;
        if (ev_clr == 0) begin
          bus.dp_events = '0;
          if (last_tx && mode == 0) data_wait = $urandom_range(2, 8);
        end
      end
      if (data_wait > 0) begin
        data_wait--;
        if (data_wait == 0) begin
          bus.dp_events = ev;
          if (w) begin
            bus.dp_busy = 1'b1;
            busy_cnt = (busy_len > 0) ? busy_len : $urandom_range(20, 50);
          end
        end
      end
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          bus.dp_busy = 1'b0;
          busy_fall = cyc;
        end
      end

      if (bus.cmd_start) begin
        ncmd++;
        if (bus.cmd_index == 6'd12) begin
          nstop++; stop_arg = bus.cmd_arg; cur_stop = 1'b1;
        end else begin
          if (ncmd == 1) begin idx0 = bus.cmd_index; arg0 = bus.cmd_arg; rx_before = (nrx > 0); end
          cur_stop = 1'b0;
        end
        cmd_wait = $urandom_range(1, 4);
      end
      if (bus.dp_rx_start) begin nrx++; last_tx = 1'b0; ev_clr = $urandom_range(1, 3); end
      if (bus.dp_tx_start) begin ntx++; last_tx = 1'b1; ev_clr = $urandom_range(1, 3); end
    end

    check("done_seen", 32'(got_done), 32'd1);
    check("ready_busy", 32'(ready_viol), 32'd0);
    check("blk", 32'(bus.dp_block_count), 32'(cnt));
    check("dma", bus.dp_dma_addr, dma);

    if (mode == 1) begin
      // Counter runs 0..all-ones over 2**W active cycles; DONE is seen one cycle later.
      check("wdog_lat", 32'(done_cyc), 32'((1 << WDOG_W) + 1));
      check("wdog_st", 32'(st), 32'd4);
      check("wdog_stop", 32'(nstop), 32'd0);
    end else if (cnt == 16'd0) begin
      check("zero_ncmd", 32'(ncmd + nrx + ntx), 32'd0);
      check("zero_lat", 32'(done_cyc), 32'd1);
      check("zero_st", 32'(st), 32'd0);
    end else begin
      if (w && cerr) begin
        exp_st = 3'd1; exp_eb = '0;
        check("cerr_lat", 32'((done_cyc - cresp_cyc) <= 2), 32'd1);
      end else begin
        exp_st = cerr ? 3'd1 : ev[1] ? 3'd2 : (multi && serr) ? 3'd3 : 3'd0;
        exp_eb = ev[6:2];
        if (w) check("busy_lat", 32'(done_cyc - busy_fall), 32'd1);
      end
      check("idx", 32'(idx0), 32'(exp_idx));
      check("arg", arg0, exp_arg);
      check("n_rx", 32'(nrx), 32'(!w));
      if (!w) check("rx_first", 32'(rx_before), 32'd1);
      check("n_tx", 32'(ntx), 32'(w && !cerr));
      check("n_stop", 32'(nstop), 32'(multi && !(w && cerr)));
      check("n_cmd", 32'(ncmd), 32'(1 + nstop));
      if (nstop > 0) check("stop_arg", stop_arg, 32'd0);
      check("status", 32'(st), 32'(exp_st));
      check("err_bits", 32'(eb), 32'(exp_eb));
    end

    @(negedge clk);
    check("done_width", 32'(bus.done), 32'd0);
    check("ready_after", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    logic       w, hc, cerr, serr, junk;
    logic [6:0] ev;
    logic [15:0] cnt;

    drive_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_init");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_rel");

    run_xfer(1'b0, 32'h10,   16'd1, 1'b0, 1'b0, 7'h01, 1'b0, 1'b0, 0,  0);
    run_xfer(1'b1, 32'h1234, 16'd4, 1'b1, 1'b0, 7'h01, 1'b0, 1'b0, 50, 0);
    run_xfer(1'b0, 32'h55,   16'd3, 1'b0, 1'b0, 7'h0A, 1'b1, 1'b0, 0,  0);
    run_xfer(1'b1, 32'h77,   16'd1, 1'b1, 1'b1, 7'h01, 1'b0, 1'b0, 0,  0);
    run_xfer(1'b0, 32'h99,   16'd0, 1'b1, 1'b0, 7'h01, 1'b0, 1'b0, 0,  0);
    run_xfer(1'b0, 32'hABC,  16'd2, 1'b1, 1'b0, 7'h01, 1'b0, 1'b1, 0,  0);
    run_xfer(1'b0, 32'h200,  16'd2, 1'b0, 1'b1, 7'h06, 1'b0, 1'b0, 0,  0);
    run_xfer(1'b0, 32'h300,  16'd2, 1'b1, 1'b0, 7'h01, 1'b0, 1'b0, 0,  1);

    for (int i = 0; i < 40; i++) begin
      w    = 1'($urandom_range(0, 1));
      hc   = 1'($urandom_range(0, 1));
      cnt  = 16'($urandom_range(0, 5));
      cerr = ($urandom_range(0, 5) == 0);
      serr = ($urandom_range(0, 3) == 0);
      junk = ($urandom_range(0, 2) == 0);
      ev   = ($urandom_range(0, 3) == 0) ? {5'($urandom_range(0, 31)), 2'b10} : 7'h01;
      run_xfer(w, $urandom, cnt, hc, cerr, ev, serr, junk, 0, 0);
    end

    run_xfer(1'b0, 32'h400, 16'd3, 1'b0, 1'b0, 7'h01, 1'b0, 1'b0, 0, 2);
    run_xfer(1'b0, 32'h11,  16'd1, 1'b1, 1'b0, 7'h01, 1'b0, 1'b0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
